// File: rtl/writeback_port_arbiter.sv
// Shares the register-file write port between the W-stage result and a small LLU result FIFO.
// Optional perf counters (ConflictCnt/ForceCnt) are enabled with `define WB_ARB_PERF_EN.
module writeback_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   RegWriteW,
  input  logic [4:0]             RdW,
  input  logic [31:0]            ResultW,
  input  logic                   LluValid,
  input  logic [4:0]             LluRd,
  input  logic [31:0]            LluData,
  output logic                   LluReady,
  output logic                   RegWriteOut,
  output logic [4:0]             RdOut,
  output logic [31:0]            WrDataOut,
  output logic                   StallWB,
  output logic                   GrantLlu,
  output logic [$clog2(DEPTH):0] PendingCnt
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]            ConflictCnt,
  output logic [31:0]            ForceCnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

  state_t        state;
  wb_ent_t       mem [DEPTH];
  wb_ent_t       head;
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_nxt;
  logic [AW-1:0] age, age_inc;
  logic          real_wr, full, push, grant;

  assign real_wr   = RegWriteW && (RdW != 5'd0);
  assign full      = (count == CW'(DEPTH));
  // x0 results complete the handshake but are dropped here
  assign push      = LluValid && !full && (LluRd != 5'd0);
  assign grant     = (state == FORCE) || ((state == PEND) && !real_wr);
  assign count_nxt = count + CW'(push) - CW'(grant);
  assign age_inc   = age + AW'(1);
  assign head      = mem[rptr];

  // Outputs are held at zero while reset is asserted, regardless of W-stage inputs
  always_comb begin
    LluReady    = rst && !full;
    RegWriteOut = 1'b0;
    RdOut       = 5'd0;
    WrDataOut   = 32'd0;
    StallWB     = 1'b0;
    GrantLlu    = 1'b0;
    PendingCnt  = count;
    if (rst) begin
      StallWB  = (state == FORCE);
      GrantLlu = grant;
      if (grant) begin
        RegWriteOut = 1'b1;
        RdOut       = head.rd;
        WrDataOut   = head.data;
      end else begin
        RegWriteOut = real_wr;
        RdOut       = RdW;
        WrDataOut   = ResultW;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{rd: LluRd, data: LluData};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      age   <= '0;
    end else begin
      if (push)  wptr <= wptr + PW'(1);
      if (grant) rptr <= rptr + PW'(1);
      count <= count_nxt;
      case (state)
        IDLE: if (push) state <= PEND;
        PEND: begin
          if (!real_wr) begin
            age <= '0;
            if (count_nxt == '0) state <= IDLE;
          end else begin
            age <= age_inc;
            if (age_inc == AW'(MAX_WAIT)) state <= FORCE;
          end
        end
        FORCE: begin
          age   <= '0;
          state <= (count_nxt != '0) ? PEND : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WB_ARB_PERF_EN
  // A conflict is a cycle where the pipeline beats a waiting head (FORCE cycles excluded)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ConflictCnt <= '0;
      ForceCnt    <= '0;
    end else begin
      if ((state == PEND) && real_wr && (ConflictCnt != 32'hFFFF_FFFF))
        ConflictCnt <= ConflictCnt + 32'd1;
      if ((state == FORCE) && (ForceCnt != 32'hFFFF_FFFF))
        ForceCnt <= ForceCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_port_arbiter.sv
// Directed bench for writeback_port_arbiter: pass-through, starvation force, full FIFO, x0, async reset.
module tb_writeback_port_arbiter;
  logic        clk, rst;
  logic        RegWriteW, LluValid, LluReady, RegWriteOut, StallWB, GrantLlu;
  logic [4:0]  RdW, LluRd, RdOut;
  logic [31:0] ResultW, LluData, WrDataOut;
  logic [1:0]  PendingCnt;
`ifdef WB_ARB_PERF_EN
  logic [31:0] ConflictCnt, ForceCnt;
`endif

  int total  = 0;
  int passed = 0;

  writeback_port_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .LluValid(LluValid), .LluRd(LluRd), .LluData(LluData),
    .LluReady(LluReady), .RegWriteOut(RegWriteOut), .RdOut(RdOut),
    .WrDataOut(WrDataOut), .StallWB(StallWB), .GrantLlu(GrantLlu),
    .PendingCnt(PendingCnt)
`ifdef WB_ARB_PERF_EN
    , .ConflictCnt(ConflictCnt), .ForceCnt(ForceCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic we, input logic [4:0] rd, input logic [31:0] d);
    RegWriteW = we; RdW = rd; ResultW = d;
  endtask

  task automatic llu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    LluValid = v; LluRd = rd; LluData = d;
  endtask

  initial begin
    rst = 1'b0;
    pipe(1'b1, 5'd3, 32'h33);
    llu(1'b0, 5'd0, 32'h0);
    #2;
    // reset: outputs forced low even with a live pipeline write
    chk("rst_regwrite", RegWriteOut, 0);
    chk("rst_ready", LluReady, 0);
    chk("rst_pending", PendingCnt, 0);
    chk("rst_grant", GrantLlu, 0);
    chk("rst_stall", StallWB, 0);
    chk("rst_rd", RdOut, 0);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rel_ready", LluReady, 1);
    chk("rel_passthru_we", RegWriteOut, 1);
    chk("rel_passthru_rd", RdOut, 3);

    // 1: idle LLU write
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    llu(1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    chk("t1_grant0", GrantLlu, 0);
    tick();
    llu(1'b0, 5'd0, 32'h0);
    #1;
    chk("t1_we", RegWriteOut, 1);
    chk("t1_rd", RdOut, 5);
    chk("t1_data", WrDataOut, 32'hDEAD_BEEF);
    chk("t1_grant", GrantLlu, 1);
    chk("t1_pend1", PendingCnt, 1);
    tick();
    chk("t1_pend0", PendingCnt, 0);
    chk("t1_grant_after", GrantLlu, 0);

    // 2: starvation -> forced grant on the 5th cycle
    pipe(1'b1, 5'd3, 32'h33);
    llu(1'b1, 5'd7, 32'h77);
    #1;
    chk("t2_enq_rd", RdOut, 3);
    tick();
    llu(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t2_defer%0d_grant", i), GrantLlu, 0);
      chk($sformatf("t2_defer%0d_rd", i), RdOut, 3);
      chk($sformatf("t2_defer%0d_stall", i), StallWB, 0);
      tick();
    end
    #1;
    chk("t2_force_stall", StallWB, 1);
    chk("t2_force_grant", GrantLlu, 1);
    chk("t2_force_rd", RdOut, 7);
    chk("t2_force_data", WrDataOut, 32'h77);
    tick();
    chk("t2_after_rd", RdOut, 3);
    chk("t2_after_we", RegWriteOut, 1);
    chk("t2_after_stall", StallWB, 0);
    chk("t2_after_pend", PendingCnt, 0);
`ifdef WB_ARB_PERF_EN
    chk("t6_conflict", ConflictCnt, 4);
    chk("t6_force", ForceCnt, 1);
`endif

    // 3: full FIFO back-pressure, pointer wrap
    llu(1'b1, 5'd8, 32'h88);
    #1;
    chk("t3_ready_a", LluReady, 1);
    tick();
    llu(1'b1, 5'd9, 32'h99);
    #1;
    chk("t3_ready_b", LluReady, 1);
    chk("t3_pend_b", PendingCnt, 1);
    chk("t3_grant_b", GrantLlu, 0);
    tick();
    llu(1'b1, 5'd10, 32'hAA);
    #1;
    chk("t3_ready_full", LluReady, 0);
    chk("t3_pend_full", PendingCnt, 2);
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    #1;
    chk("t3_still_full", LluReady, 0);
    chk("t3_pend_max", PendingCnt, 2);
    chk("t3_head8", RdOut, 8);
    chk("t3_data8", WrDataOut, 32'h88);
    tick();
    chk("t3_ready_free", LluReady, 1);
    chk("t3_head9", RdOut, 9);
    chk("t3_pend_c", PendingCnt, 1);
    tick();
    llu(1'b0, 5'd0, 32'h0);
    #1;
    chk("t3_head10", RdOut, 10);
    chk("t3_data10", WrDataOut, 32'hAA);
    chk("t3_pend_d", PendingCnt, 1);
    tick();
    chk("t3_empty", PendingCnt, 0);
    chk("t3_no_write", RegWriteOut, 0);

    // 4: x0 handling
    llu(1'b1, 5'd0, 32'h123);
    #1;
    chk("t4_x0_ready", LluReady, 1);
    tick();
    llu(1'b0, 5'd0, 32'h0);
    #1;
    chk("t4_x0_pend", PendingCnt, 0);
    chk("t4_x0_we", RegWriteOut, 0);
    pipe(1'b1, 5'd0, 32'h55);
    llu(1'b1, 5'd12, 32'hC);
    #1;
    chk("t4_rd0_nowrite", RegWriteOut, 0);
    tick();
    llu(1'b0, 5'd0, 32'h0);
    #1;
    chk("t4_head_grant", GrantLlu, 1);
    chk("t4_head_nostall", StallWB, 0);
    chk("t4_head_rd", RdOut, 12);
    chk("t4_head_we", RegWriteOut, 1);
    tick();

    // 5: async reset in a FORCE cycle with two entries pending
    pipe(1'b1, 5'd3, 32'h33);
    llu(1'b1, 5'd20, 32'h20);
    tick();
    llu(1'b1, 5'd21, 32'h21);
    tick();
    llu(1'b0, 5'd0, 32'h0);
    tick(); tick(); tick();
    #1;
    chk("t5_force", StallWB, 1);
    chk("t5_force_rd", RdOut, 20);
    chk("t5_pend2", PendingCnt, 2);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_we0", RegWriteOut, 0);
    chk("t5_rd0", RdOut, 0);
    chk("t5_data0", WrDataOut, 0);
    chk("t5_stall0", StallWB, 0);
    chk("t5_grant0", GrantLlu, 0);
    chk("t5_pend0", PendingCnt, 0);
    chk("t5_ready0", LluReady, 0);
    tick();
    pipe(1'b0, 5'd0, 32'h0);
    rst = 1'b1;
    #1;
    chk("t5_rel_ready", LluReady, 1);
    chk("t5_rel_pend", PendingCnt, 0);
    chk("t5_rel_we", RegWriteOut, 0);
    tick();
    chk("t5_stale_we", RegWriteOut, 0);
    chk("t5_stale_grant", GrantLlu, 0);
    chk("t5_stale_pend", PendingCnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
